// File: rtl/digital_clock_timebase.sv
// Timebase strobes for the digital clock: scan, second, minute and hour enables plus a 1 Hz square wave.
// Optional macro TIMEBASE_FAST_EN adds the `fast` port that switches the second divisor to FAST_DIV.
module digital_clock_timebase #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 5000,
  parameter int unsigned FAST_HZ = 1000
) (
  input  logic       fpga_clk,
  input  logic       rst,
  input  logic       run,
  input  logic       resync,
`ifdef TIMEBASE_FAST_EN
  input  logic       fast,
`endif
  output logic       scan_tick,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       sec_clk,
  output logic [5:0] sec_cnt,
  output logic [5:0] min_cnt
);

  localparam int unsigned SEC_DIV  = CLK_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW       = $clog2(CLK_HZ);
  localparam int unsigned SW       = $clog2(SCAN_DIV);

  logic [PW-1:0] presc, presc_nx;
  logic [SW-1:0] scan_q, scan_nx;
  logic [31:0]   div;
  logic [5:0]    sec_nx, min_nx;
  logic          scan_tick_nx, sec_evt, min_evt, hour_evt, sec_clk_nx;

`ifdef TIMEBASE_FAST_EN
  localparam int unsigned FAST_DIV = CLK_HZ / FAST_HZ;
  assign div = fast ? FAST_DIV : SEC_DIV;
`else
  assign div = SEC_DIV;
  // FAST_HZ has no effect in this build
  if (FAST_HZ == 0) begin : g_fast_hz_ignored
  end
`endif

  // Free-running scan divider
  always_comb begin
    scan_tick_nx = (scan_q == SW'(SCAN_DIV - 1));
    scan_nx      = scan_tick_nx ? '0 : scan_q + SW'(1);
  end

  // Second prescaler and seconds/minutes counts
  always_comb begin
    presc_nx   = presc;
    sec_nx     = sec_cnt;
    min_nx     = min_cnt;
    sec_evt    = 1'b0;
    min_evt    = 1'b0;
    hour_evt   = 1'b0;
    sec_clk_nx = sec_clk;
    if (resync) begin
      presc_nx   = '0;
      sec_nx     = '0;
      min_nx     = '0;
      sec_clk_nx = 1'b1;
    end else if (run) begin
      // >= keeps a shortened divisor from overrunning the terminal
      if (32'(presc) >= div - 32'd1) begin
        presc_nx = '0;
        sec_evt  = 1'b1;
        if (sec_cnt == 6'd59) begin
          sec_nx  = '0;
          min_evt = 1'b1;
          if (min_cnt == 6'd59) begin
            min_nx   = '0;
            hour_evt = 1'b1;
          end else begin
            min_nx = min_cnt + 6'd1;
          end
        end else begin
          sec_nx = sec_cnt + 6'd1;
        end
      end else begin
        presc_nx = presc + PW'(1);
      end
      sec_clk_nx = ((32'(presc_nx) << 1) < div);
    end
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      presc     <= '0;
      scan_q    <= '0;
      sec_cnt   <= '0;
      min_cnt   <= '0;
      scan_tick <= 1'b0;
      sec_tick  <= 1'b0;
      min_tick  <= 1'b0;
      hour_tick <= 1'b0;
      sec_clk   <= 1'b1;
    end else begin
      presc     <= presc_nx;
      scan_q    <= scan_nx;
      sec_cnt   <= sec_nx;
      min_cnt   <= min_nx;
      scan_tick <= scan_tick_nx;
      sec_tick  <= sec_evt;
      min_tick  <= min_evt;
      hour_tick <= hour_evt;
      sec_clk   <= sec_clk_nx;
    end
  end

endmodule

// File: tb/tb_digital_clock_timebase.sv
// Randomised and directed bench for digital_clock_timebase against a phase/elapsed-seconds model.
module tb_digital_clock_timebase;

  localparam int unsigned CLK_HZ   = 20;
  localparam int unsigned SCAN_HZ  = 5;
  localparam int unsigned FAST_HZ  = 10;
  localparam int unsigned SEC_DIV  = CLK_HZ;
  localparam int unsigned SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned FAST_DIV = CLK_HZ / FAST_HZ;

  logic       fpga_clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       resync = 1'b0;
`ifdef TIMEBASE_FAST_EN
  logic       fast = 1'b0;
`endif
  logic       scan_tick, sec_tick, min_tick, hour_tick, sec_clk;
  logic [5:0] sec_cnt, min_cnt;

  int checks = 0;
  int failures = 0;

  // Model: phase within the current second, elapsed seconds, cycles since reset
  int phase = 0;
  int secs = 0;
  int scyc = 0;
  bit m_scan, m_sec, m_min, m_hour, m_clk;
  bit valid = 1'b0;

  always #5 fpga_clk = ~fpga_clk;

  digital_clock_timebase #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .FAST_HZ(FAST_HZ)
  ) dut (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .run      (run),
    .resync   (resync),
`ifdef TIMEBASE_FAST_EN
    .fast     (fast),
`endif
    .scan_tick(scan_tick),
    .sec_tick (sec_tick),
    .min_tick (min_tick),
    .hour_tick(hour_tick),
    .sec_clk  (sec_clk),
    .sec_cnt  (sec_cnt),
    .min_cnt  (min_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit rn, input bit rs, input bit f);
    int d;
    d = f ? FAST_DIV : SEC_DIV;
    if (r) begin
      valid = 1'b1;
      phase = 0; secs = 0; scyc = 0;
      m_scan = 0; m_sec = 0; m_min = 0; m_hour = 0; m_clk = 1;
      return;
    end
    scyc++;
    m_scan = (scyc % SCAN_DIV) == 0;
    m_sec = 0; m_min = 0; m_hour = 0;
    if (rs) begin
      phase = 0; secs = 0; m_clk = 1;
    end else if (rn) begin
      if (phase >= d - 1) begin
        phase = 0;
        secs++;
        m_sec  = 1;
        m_min  = (secs % 60) == 0;
        m_hour = (secs % 3600) == 0;
      end else begin
        phase++;
      end
      m_clk = (2 * phase) < d;
    end
  endtask

  // One clock: advance the model with the sampled inputs, then compare every output
  task automatic step();
    bit f;
    @(posedge fpga_clk);
    f = 1'b0;
`ifdef TIMEBASE_FAST_EN
    f = fast;
`endif
    model_edge(rst, run, resync, f);
    #1;
    if (valid) begin
      check("scan_tick", int'(scan_tick), int'(m_scan));
      check("sec_tick",  int'(sec_tick),  int'(m_sec));
      check("min_tick",  int'(min_tick),  int'(m_min));
      check("hour_tick", int'(hour_tick), int'(m_hour));
      check("sec_clk",   int'(sec_clk),   int'(m_clk));
      check("sec_cnt",   int'(sec_cnt),   secs % 60);
      check("min_cnt",   int'(min_cnt),   (secs / 60) % 60);
    end
  endtask

  task automatic wait_sec_tick(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sec_tick !== 1'b1 && n < max);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int n, first_scan, first_sec, mins, hours, scans, secs_seen;

  initial begin
    // Reset and free-run
    resync = 1'b0;
    run = 1'b1;
    do_reset();
    first_scan = 0; first_sec = 0;
    for (int i = 1; i <= 24; i++) begin
      step();
      if (scan_tick && first_scan == 0) first_scan = i;
      if (sec_tick && first_sec == 0) first_sec = i;
      if (i == 9)  check("sec_clk_high_end", int'(sec_clk), 1);
      if (i == 10) check("sec_clk_low_start", int'(sec_clk), 0);
      if (i == 20) check("sec_clk_rise", int'(sec_clk), 1);
    end
    check("first_scan", first_scan, 4);
    check("first_sec", first_sec, 20);
    wait_sec_tick(30, n);
    check("sec_period", n, 16);

    // Minute/hour wrap over one simulated hour
    do_reset();
    mins = 0; hours = 0;
    for (int i = 0; i < 72000; i++) begin
      step();
      if (min_tick) mins++;
      if (hour_tick) hours++;
    end
    check("min_ticks", mins, 60);
    check("hour_ticks", hours, 1);
    check("hour_tick_last", int'(hour_tick), 1);
    check("hour_sec_cnt", int'(sec_cnt), 0);
    check("hour_min_cnt", int'(min_cnt), 0);

    // Pause at prescaler 12
    do_reset();
    repeat (12) step();
    run = 1'b0;
    scans = 0; secs_seen = 0;
    repeat (7) begin
      step();
      if (scan_tick) scans++;
      if (sec_tick) secs_seen++;
    end
    check("pause_scans", scans, 1);
    check("pause_secs", secs_seen, 0);
    run = 1'b1;
    wait_sec_tick(30, n);
    check("resume_sec", n, 8);

    // Resync coincident with terminal count at sec_cnt 33
    do_reset();
    repeat (679) step();
    check("pre_resync_sec_cnt", int'(sec_cnt), 33);
    resync = 1'b1;
    step();
    check("resync_sec_tick", int'(sec_tick), 0);
    check("resync_sec_cnt", int'(sec_cnt), 0);
    check("resync_sec_clk", int'(sec_clk), 1);
    resync = 1'b0;
    wait_sec_tick(30, n);
    check("post_resync_sec", n, 20);

    // Mid-count reset
    repeat (300) step();
    rst = 1'b1;
    step();
    check("rst_scan", int'(scan_tick), 0);
    check("rst_sec", int'(sec_tick), 0);
    check("rst_min", int'(min_tick), 0);
    check("rst_hour", int'(hour_tick), 0);
    check("rst_clk", int'(sec_clk), 1);
    check("rst_sec_cnt", int'(sec_cnt), 0);
    check("rst_min_cnt", int'(min_cnt), 0);
    rst = 1'b0;
    first_scan = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (scan_tick && first_scan == 0) first_scan = i;
    end
    check("rst_first_scan", first_scan, 4);

`ifdef TIMEBASE_FAST_EN
    // Fast switch at prescaler 15
    do_reset();
    repeat (15) step();
    fast = 1'b1;
    step();
    check("fast_wrap", int'(sec_tick), 1);
    step();
    check("fast_gap", int'(sec_tick), 0);
    step();
    check("fast_next", int'(sec_tick), 1);
    fast = 1'b0;
`endif

    // Randomised control traffic
    for (int i = 0; i < 6000; i++) begin
      rst    = ($urandom_range(499) == 0);
      resync = ($urandom_range(39) == 0);
      run    = ($urandom_range(7) != 0);
`ifdef TIMEBASE_FAST_EN
      if ($urandom_range(49) == 0) fast = ~fast;
`endif
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digital_clock_timebase.md
# digital_clock_timebase

Parametrised timebase for the digital clock. It divides `fpga_clk` into single-cycle enable strobes: display scan, second, minute and hour. It also provides a 50 % duty 1 Hz square wave and live seconds/minutes counts. Downstream counters and the display multiplexer run on `fpga_clk` and are gated by these strobes instead of derived clocks. Run/pause and resync controls support time setting.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: input clock frequency; `SEC_DIV = CLK_HZ` cycles per second.
- `SCAN_HZ`, 5000: scan strobe rate; `SCAN_DIV = CLK_HZ / SCAN_HZ`, must be ≥ 2.
- `FAST_HZ`, 1000: second-strobe rate in fast mode; `FAST_DIV = CLK_HZ / FAST_HZ`, must be ≥ 2 (only used with `TIMEBASE_FAST_EN`).

Ports:
- `fpga_clk`  in  1  sole clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  1 = time advances; 0 = prescaler and counts hold.
- `resync`  in  1  synchronous clear of prescaler, `sec_cnt` and `min_cnt`.
- `fast`  in  1  selects `FAST_DIV` as the second divisor (present only with `TIMEBASE_FAST_EN`).
- `scan_tick`  out  1  one-cycle strobe every `SCAN_DIV` cycles.
- `sec_tick`  out  1  one-cycle strobe per second.
- `min_tick`  out  1  one-cycle strobe on the 59→0 wrap of `sec_cnt`.
- `hour_tick`  out  1  one-cycle strobe on the 59→0 wrap of `min_cnt`.
- `sec_clk`  out  1  square wave at one period per second.
- `sec_cnt`  out  6  seconds, 0..59.
- `min_cnt`  out  6  minutes, 0..59.

## Operation
- **Registers.** All outputs are registered.
  - Prescaler width: `$clog2(CLK_HZ)`.
  - Scan counter width: `$clog2(SCAN_DIV)`.
- **Priority.** `rst` > `resync` > `run`.
- **Reset values.** Prescaler = 0, scan counter = 0, `sec_cnt` = 0, `min_cnt` = 0, all ticks = 0, `sec_clk` = 1.
- **Scan path.**
  - The scan counter is free-running and ignores `run` and `resync`. It counts 0..`SCAN_DIV`-1 and wraps.
  - `scan_tick` is high in the cycle after the counter reaches `SCAN_DIV`-1.
- **Second prescaler.**
  - Divisor `D` = `SEC_DIV`, or `FAST_DIV` when fast mode is active.
  - With `run`=1, the prescaler increments each cycle.
  - At terminal (prescaler ≥ `D`-1, using ≥ so a divisor change mid-count is safe), the prescaler wraps to 0 and `sec_tick` is asserted for the following cycle.
- **Seconds/minutes.**
  - On each second event, `sec_cnt` increments, wrapping 59→0.
  - On the wrap, `min_tick` is asserted and `min_cnt` increments.
  - On the `min_cnt` 59→0 wrap, `hour_tick` is asserted.
  - The ticks, the new `sec_cnt` and the new `min_cnt` all appear in the same cycle.
- **Pause (`run`=0).**
  - Prescaler, counts and `sec_clk` hold; `sec_tick`/`min_tick`/`hour_tick` are 0.
  - `scan_tick` continues.
  - Resuming continues from the held phase, with no lost or extra tick.
- **Resync (`resync`=1).**
  - Prescaler, `sec_cnt` and `min_cnt` go to 0; `sec_clk` goes to 1; second/minute/hour ticks are 0 that cycle.
  - If `resync` is held, the block stays cleared.
  - Resync wins over a coincident terminal count, so no tick is emitted.
- **`sec_clk`.** Registered as (next prescaler < `D`/2). It is high `ceil(D/2)` cycles and low `floor(D/2)` cycles, and rises in the same cycle `sec_tick` is high.

## Timing
- **First second.** When `rst` is sampled high at edge E0 and `run`=1 thereafter, `sec_tick` is first high after edge E0+`D`. Its period is then exactly `D` cycles.
- **First scan.** `scan_tick` is first high after edge E0+`SCAN_DIV`; its period is `SCAN_DIV`.
- **Strobe periods.** `min_tick` every 60·`D` cycles; `hour_tick` every 3600·`D` cycles.
- **Control latency.** Zero extra latency from `run`/`resync` to counter state: they act on the edge at which they are sampled.
- **Fast mode.**
  - Switching `fast` takes effect on the next terminal compare.
  - If the prescaler is already ≥ `FAST_DIV`-1 when fast is selected, the wrap occurs on the next edge.

## Configuration
- **`TIMEBASE_FAST_EN` defined:**
  - The `fast` port exists.
  - `D` = `FAST_DIV` while `fast`=1, for accelerated time setting and simulation.
- **Not defined:**
  - There is no `fast` port and `D` is fixed at `SEC_DIV`.
  - The `FAST_HZ` parameter is ignored and no fast-mode logic is synthesised.

## Test plan
All scenarios use `CLK_HZ`=20, `SCAN_HZ`=5, `FAST_HZ`=10.
1. **Reset and free-run.** Apply `rst`, then hold `run`=1 → `scan_tick` every 4 cycles; `sec_tick` first 20 cycles after the reset edge, then every 20; `sec_clk` high 10 / low 10, rising with `sec_tick`.
2. **Minute/hour wrap.** Run 72000 cycles → `sec_cnt` 59→0 with `min_tick`; `min_cnt` 59→0 with `hour_tick`, coincident with `sec_tick`; exactly 60 `min_tick` and 1 `hour_tick`.
3. **Pause.** Drop `run` for 7 cycles at prescaler 12 → no tick, counts held, `scan_tick` still every 4 cycles; next `sec_tick` 8 cycles after `run` returns.
4. **Resync vs terminal.** Assert `resync` when prescaler = 19 and `sec_cnt` = 33 → no `sec_tick`, `sec_cnt`=0, `sec_clk`=1; next `sec_tick` 20 cycles after `resync` falls.
5. **Mid-count reset.** Assert `rst` mid-minute → all outputs at reset values the next cycle, with scan phase also cleared.
6. **Fast switch (`TIMEBASE_FAST_EN` only).** Set `fast`=1 at prescaler 15 → wrap on the next edge, then `sec_tick` every 2 cycles with `sec_clk` 1/1.
